// File: rtl/eth_f_pkt_client_pkg.sv
// ============================================================================
// Module      : eth_f_pkt_client_pkg
// Description : Shared types and constants for the 25G packet client
//               generator and checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_f_pkt_client_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_IPG     = 3'd4
    } pkt_gen_state_t;

    localparam logic [63:0] PAYLOAD_SEED = 64'h11223344_10203040;
    localparam logic [15:0] SEQ_OFFSET   = 16'h002A;
    localparam logic [15:0] PKT_ETYPE    = 16'h88B5;

    // Byte 0 lives in [63:56], so unused bytes are cleared from the bottom up.
    function automatic logic [63:0] empty_to_mask(input logic [3:0] empty);
        empty_to_mask = {64{1'b1}} << {empty, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_f_packet_client_data_gen_25g.sv
// ============================================================================
// Module      : eth_f_packet_client_data_gen_25g
// Description : 64-bit Avalon-ST packet generator (header + incrementing
//               payload) feeding the 25G MAC, one-shot or continuous mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_f_packet_client_data_gen_25g
    import eth_f_pkt_client_pkg::*;
#(
    parameter int DATA_BCNT = 8,
    parameter int MAX_LEN   = 9600,
    parameter int MIN_LEN   = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cfg_pkt_gen_tx_en,
    input  logic        i_cfg_pkt_gen_cont_mode,
    input  logic [31:0] i_cfg_pkt_num,
    input  logic [13:0] i_cfg_pkt_len,
    input  logic [7:0]  i_cfg_ipg,
    input  logic [31:0] i_cfg_hdr_tag,
    input  logic        i_tx_ready,
    output logic        o_tx_valid,
    output logic        o_tx_sop,
    output logic        o_tx_eop,
    output logic [3:0]  o_tx_empty,
    output logic [63:0] o_tx_data,
    output logic [31:0] o_pkt_cnt,
    output logic        o_done
);

    localparam logic [13:0] c_min_len = 14'(MIN_LEN);
    localparam logic [13:0] c_max_len = 14'(MAX_LEN);
    localparam logic [13:0] c_bcnt    = 14'(DATA_BCNT);

    pkt_gen_state_t r_state;
    pkt_gen_state_t w_state_next;

    logic        r_tx_en_d;
    logic [31:0] r_pkt_cnt;
    logic        r_done;
    logic [63:0] r_payload;
    logic [13:0] r_len_c;
    logic [13:0] r_beats;
    logic [13:0] r_beat_cnt;
    logic [3:0]  r_empty;
    logic [7:0]  r_ipg_cnt;

    logic        w_valid;
    logic        w_en_rise;
    logic        w_accept;
    logic        w_last_beat;
    logic        w_eop_accept;
    logic [31:0] w_cnt_next;
    logic        w_more;
    logic        w_decide;
    logic        w_start;
    logic        w_set_done;
    logic [13:0] w_len_c;
    logic [13:0] w_beats;
    logic [3:0]  w_empty;

    assign w_len_c = (i_cfg_pkt_len < c_min_len) ? c_min_len :
                     (i_cfg_pkt_len > c_max_len) ? c_max_len : i_cfg_pkt_len;
    assign w_beats = (w_len_c + (c_bcnt - 14'd1)) / c_bcnt;
    assign w_empty = 4'((c_bcnt - (w_len_c % c_bcnt)) % c_bcnt);

    assign w_valid      = (r_state == ST_HDR0) || (r_state == ST_HDR1) || (r_state == ST_PAYLOAD);
    assign w_en_rise    = i_cfg_pkt_gen_tx_en & ~r_tx_en_d;
    assign w_accept     = w_valid & i_tx_ready;
    assign w_last_beat  = (r_state == ST_PAYLOAD) && (r_beat_cnt == r_beats - 14'd1);
    assign w_eop_accept = w_accept & w_last_beat;

    // Count as it will be after this edge; every start/stop decision uses it.
    assign w_cnt_next = (w_en_rise ? 32'd0 : r_pkt_cnt) + {31'd0, w_eop_accept};
    assign w_more     = i_cfg_pkt_gen_tx_en &
                        (i_cfg_pkt_gen_cont_mode | (w_cnt_next < i_cfg_pkt_num));
    assign w_start    = w_decide & w_more;
    assign w_set_done = w_decide & ~i_cfg_pkt_gen_cont_mode & ~(w_cnt_next < i_cfg_pkt_num);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_decide     = 1'b0;
        o_tx_sop     = 1'b0;
        o_tx_eop     = 1'b0;
        o_tx_empty   = 4'd0;
        o_tx_data    = 64'd0;
        case (r_state)
            ST_IDLE: begin
                w_decide = i_cfg_pkt_gen_tx_en;
            end
            ST_HDR0: begin
                o_tx_sop  = 1'b1;
                o_tx_data = {i_cfg_hdr_tag, r_pkt_cnt[15:0] + SEQ_OFFSET, PKT_ETYPE};
                if (i_tx_ready) begin
                    w_state_next = ST_HDR1;
                end
            end
            ST_HDR1: begin
                o_tx_data = {16'h0, {2'b00, r_len_c}, r_pkt_cnt};
                if (i_tx_ready) begin
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                o_tx_data = r_payload;
                if (w_last_beat) begin
                    o_tx_eop   = 1'b1;
                    o_tx_empty = r_empty;
                    o_tx_data  = r_payload & empty_to_mask(r_empty);
                    if (i_tx_ready) begin
                        if (i_cfg_ipg != 8'd0) begin
                            w_state_next = ST_IPG;
                        end else begin
                            w_decide = 1'b1;
                        end
                    end
                end
            end
            ST_IPG: begin
                w_decide = (r_ipg_cnt == 8'd0);
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_decide) begin
            w_state_next = w_more ? ST_HDR0 : ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_en_d  <= 1'b0;
            r_pkt_cnt  <= 32'd0;
            r_done     <= 1'b0;
            r_payload  <= PAYLOAD_SEED;
            r_len_c    <= 14'd0;
            r_beats    <= 14'd0;
            r_beat_cnt <= 14'd0;
            r_empty    <= 4'd0;
            r_ipg_cnt  <= 8'd0;
        end else begin
            r_tx_en_d <= i_cfg_pkt_gen_tx_en;
            r_pkt_cnt <= w_cnt_next;

            if (i_cfg_pkt_gen_cont_mode) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end else if (w_en_rise) begin
                r_done <= 1'b0;
            end

            // Length is frozen at packet start so mid-packet config edits are ignored.
            if (w_start) begin
                r_len_c <= w_len_c;
                r_beats <= w_beats;
                r_empty <= w_empty;
            end

            if (w_accept && (r_state == ST_HDR1)) begin
                r_beat_cnt <= 14'd2;
            end else if (w_accept && (r_state == ST_PAYLOAD)) begin
                r_beat_cnt <= r_beat_cnt + 14'd1;
            end

            if (w_accept && (r_state == ST_PAYLOAD)) begin
                r_payload <= r_payload + 64'd1;
            end

            if (w_eop_accept) begin
                r_ipg_cnt <= i_cfg_ipg - 8'd1;
            end else if ((r_state == ST_IPG) && (r_ipg_cnt != 8'd0)) begin
                r_ipg_cnt <= r_ipg_cnt - 8'd1;
            end
        end
    end

    assign o_tx_valid = w_valid;
    assign o_pkt_cnt  = r_pkt_cnt;
    assign o_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_eth_f_packet_client_data_gen_25g.sv
// ============================================================================
// Module      : tb_eth_f_packet_client_data_gen_25g
// Description : Self-checking bench for the 25G packet generator against a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_eth_f_packet_client_data_gen_25g;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cfg_pkt_gen_tx_en;
    logic        i_cfg_pkt_gen_cont_mode;
    logic [31:0] i_cfg_pkt_num;
    logic [13:0] i_cfg_pkt_len;
    logic [7:0]  i_cfg_ipg;
    logic [31:0] i_cfg_hdr_tag;
    logic        i_tx_ready;
    logic        o_tx_valid;
    logic        o_tx_sop;
    logic        o_tx_eop;
    logic [3:0]  o_tx_empty;
    logic [63:0] o_tx_data;
    logic [31:0] o_pkt_cnt;
    logic        o_done;

    eth_f_packet_client_data_gen_25g dut (
        .i_clk                   (i_clk),
        .i_reset                 (i_reset),
        .i_cfg_pkt_gen_tx_en     (i_cfg_pkt_gen_tx_en),
        .i_cfg_pkt_gen_cont_mode (i_cfg_pkt_gen_cont_mode),
        .i_cfg_pkt_num           (i_cfg_pkt_num),
        .i_cfg_pkt_len           (i_cfg_pkt_len),
        .i_cfg_ipg               (i_cfg_ipg),
        .i_cfg_hdr_tag           (i_cfg_hdr_tag),
        .i_tx_ready              (i_tx_ready),
        .o_tx_valid              (o_tx_valid),
        .o_tx_sop                (o_tx_sop),
        .o_tx_eop                (o_tx_eop),
        .o_tx_empty              (o_tx_empty),
        .o_tx_data               (o_tx_data),
        .o_pkt_cnt               (o_pkt_cnt),
        .o_done                  (o_done)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [63:0] SEED = 64'h11223344_10203040;

    int          n_checks = 0;
    int          n_fails  = 0;
    bit          rand_ready = 1'b0;

    // Reference model state: packet-level view of the expected stream.
    logic [63:0] m_payload;
    logic [31:0] m_cnt;
    int          m_b;
    int          m_len;
    int          m_beats;
    int          m_gap;
    int          last_gap;
    int          last_pkt_beats;
    int          total_beats;
    logic [3:0]  last_eop_empty;
    logic [63:0] first_payload;
    logic [63:0] last_hdr0;
    logic [63:0] saved_payload;

    logic        p_valid;
    logic        p_ready;
    logic        p_sop;
    logic        p_eop;
    logic [3:0]  p_empty;
    logic [63:0] p_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l < 64)   return 64;
        if (l > 9600) return 9600;
        return l;
    endfunction

    function automatic logic [63:0] keep_mask(input int nbytes);
        logic [63:0] m;
        m = 64'd0;
        for (int j = 0; j < 8; j++) begin
            if (j < nbytes) m[63 - 8*j -: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic model_beat();
        logic [63:0] exp_data;
        logic        exp_eop;
        int          vbytes;
        if (m_b == 0) begin
            m_len    = clamp_len(int'(i_cfg_pkt_len));
            m_beats  = (m_len + 7) / 8;
            last_gap = m_gap;
        end
        exp_eop = (m_b == m_beats - 1);
        vbytes  = m_len - 8 * (m_beats - 1);
        if (m_b == 0) begin
            exp_data  = {i_cfg_hdr_tag, 16'(m_cnt + 32'd42), 16'h88B5};
            last_hdr0 = o_tx_data;
        end else if (m_b == 1) begin
            exp_data = {16'h0, 16'(m_len), m_cnt};
        end else begin
            exp_data  = exp_eop ? (m_payload & keep_mask(vbytes)) : m_payload;
            if (m_b == 2) first_payload = o_tx_data;
            m_payload = m_payload + 64'd1;
        end
        check("beat_data", o_tx_data, exp_data);
        check("beat_ctl", 64'({o_tx_sop, o_tx_eop, o_tx_empty}),
              64'({m_b == 0, exp_eop, 4'(exp_eop ? 8 - vbytes : 0)}));
        total_beats++;
        if (exp_eop) begin
            m_cnt          = m_cnt + 32'd1;
            last_pkt_beats = m_beats;
            last_eop_empty = o_tx_empty;
            m_b            = 0;
            m_gap          = 0;
        end else begin
            m_b++;
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (i_reset) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                check("stall_data", o_tx_data, p_data);
                check("stall_ctl", 64'({o_tx_valid, o_tx_sop, o_tx_eop, o_tx_empty}),
                      64'({1'b1, p_sop, p_eop, p_empty}));
            end
            if (m_b != 0) check("valid_mid_pkt", 64'(o_tx_valid), 64'(1));
            if (o_tx_valid && i_tx_ready) model_beat();
            else if (!o_tx_valid) m_gap++;
            p_valid = o_tx_valid;
            p_ready = i_tx_ready;
            p_sop   = o_tx_sop;
            p_eop   = o_tx_eop;
            p_empty = o_tx_empty;
            p_data  = o_tx_data;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int k;
        k = 0;
        while (m_cnt != 32'(target) && k < budget) begin
            tick();
            k++;
        end
        check("wait_pkts", 64'(m_cnt), 64'(target));
    endtask

    task automatic wait_beat(input int b, input int budget);
        int k;
        k = 0;
        while (m_b != b && k < budget) begin
            tick();
            k++;
        end
        check("wait_beat", 64'(m_b), 64'(b));
    endtask

    task automatic one_shot(input int len, input int num, input int budget);
        i_cfg_pkt_gen_tx_en = 1'b0;
        tick();
        i_cfg_pkt_gen_cont_mode = 1'b0;
        i_cfg_pkt_len           = 14'(len);
        i_cfg_pkt_num           = 32'(num);
        i_cfg_ipg               = 8'd0;
        i_cfg_hdr_tag           = $urandom;
        i_cfg_pkt_gen_tx_en     = 1'b1;
        m_cnt                   = 32'd0;
        wait_pkts(num, budget);
        ticks(2);
        check("os_pkt_cnt", 64'(o_pkt_cnt), 64'(num));
        check("os_done", 64'(o_done), 64'(1));
    endtask

    initial begin
        i_reset = 1'b1;
        i_cfg_pkt_gen_tx_en = 1'b0;
        i_cfg_pkt_gen_cont_mode = 1'b0;
        i_cfg_pkt_num = 32'd0;
        i_cfg_pkt_len = 14'd64;
        i_cfg_ipg = 8'd0;
        i_cfg_hdr_tag = 32'hCAFE_0001;
        i_tx_ready = 1'b1;
        m_payload = SEED; m_cnt = 32'd0; m_b = 0; m_gap = 0; last_gap = -1;
        last_pkt_beats = 0; total_beats = 0; last_eop_empty = 4'd0;
        first_payload = 64'd0; last_hdr0 = 64'd0; saved_payload = 64'd0;
        p_valid = 1'b0; p_ready = 1'b1; p_sop = 1'b0; p_eop = 1'b0;
        p_empty = 4'd0; p_data = 64'd0;

        // Reset state
        ticks(3);
        check("rst_ctl", 64'({o_tx_valid, o_tx_sop, o_tx_eop, o_tx_empty, o_done}), 64'd0);
        check("rst_data", o_tx_data, 64'd0);
        check("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
        i_reset = 1'b0;
        ticks(2);

        // len=64, two back-to-back one-shot packets
        one_shot(64, 2, 100);
        check("t1_total_beats", 64'(total_beats), 64'd16);
        check("t1_gap", 64'(last_gap), 64'd0);
        check("t1_pkt1_seq", 64'(last_hdr0[31:16]), 64'h002B);
        check("t1_pkt1_payload", first_payload, 64'h11223344_10203046);
        ticks(3);
        check("t1_idle", 64'(o_tx_valid), 64'd0);

        // pkt_num = 0: nothing sent, done one cycle after enable
        i_cfg_pkt_gen_tx_en = 1'b0;
        tick();
        i_cfg_pkt_num = 32'd0;
        i_cfg_pkt_gen_tx_en = 1'b1;
        m_cnt = 32'd0;
        tick();
        check("num0_done", 64'(o_done), 64'd1);
        ticks(3);
        check("num0_idle", 64'({o_tx_valid, o_pkt_cnt}), 64'd0);

        // Length edge cases
        one_shot(65, 1, 100);
        check("len65_beats", 64'(last_pkt_beats), 64'd9);
        check("len65_empty", 64'(last_eop_empty), 64'd7);
        one_shot(10, 1, 100);
        check("len10_beats", 64'(last_pkt_beats), 64'd8);
        one_shot(12000, 1, 1300);
        check("len12000_beats", 64'(last_pkt_beats), 64'd1200);
        check("len12000_empty", 64'(last_eop_empty), 64'd0);

        // Random backpressure with a random length
        rand_ready = 1'b1;
        one_shot(int'($urandom_range(64, 300)), 2, 2000);
        rand_ready = 1'b0;

        // Continuous mode with IPG, enable dropped mid-packet
        i_cfg_pkt_gen_tx_en = 1'b0;
        tick();
        i_cfg_pkt_gen_cont_mode = 1'b1;
        i_cfg_ipg = 8'd3;
        i_cfg_pkt_len = 14'd80;
        i_cfg_pkt_gen_tx_en = 1'b1;
        m_cnt = 32'd0;
        wait_pkts(2, 200);
        wait_beat(4, 100);
        check("cont_gap", 64'(last_gap), 64'd3);
        i_cfg_pkt_gen_tx_en = 1'b0;
        wait_pkts(3, 100);
        ticks(10);
        check("drop_idle_gap", 64'(m_gap), 64'd10);
        check("drop_pkt_cnt", 64'(o_pkt_cnt), 64'd3);
        check("drop_done", 64'(o_done), 64'd0);
        saved_payload = m_payload;
        i_cfg_pkt_gen_cont_mode = 1'b0;
        i_cfg_pkt_num = 32'd1;
        i_cfg_pkt_gen_tx_en = 1'b1;
        m_cnt = 32'd0;
        wait_pkts(1, 100);
        ticks(2);
        check("reen_seq", 64'(last_hdr0[31:16]), 64'h002A);
        check("reen_payload", first_payload, saved_payload);
        check("reen_pkt_cnt", 64'(o_pkt_cnt), 64'd1);

        // Reset in the middle of the payload
        i_cfg_pkt_gen_tx_en = 1'b0;
        tick();
        i_cfg_pkt_gen_cont_mode = 1'b1;
        i_cfg_ipg = 8'd0;
        i_cfg_pkt_len = 14'd64;
        i_cfg_pkt_gen_tx_en = 1'b1;
        m_cnt = 32'd0;
        wait_beat(3, 100);
        i_reset = 1'b1;
        tick();
        check("rstmid_valid", 64'(o_tx_valid), 64'd0);
        check("rstmid_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
        m_payload = SEED; m_cnt = 32'd0; m_b = 0; m_gap = 0;
        i_cfg_pkt_gen_cont_mode = 1'b0;
        i_cfg_pkt_num = 32'd1;
        i_reset = 1'b0;
        wait_pkts(1, 100);
        ticks(2);
        check("rstmid_first_payload", first_payload, SEED);
        check("rstmid_done", 64'(o_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
